// File: rtl/acceso_pkg.sv
// -----------------------------------------------------------------------------
// acceso_pkg
// Shared definitions for the two-lane parking access arbiter:
//   - estado_t     : arbiter FSM state encoding
//   - CLAVE_W      : PIN width presented to the shared validator
//   - N_CARRILES   : number of entry lanes
//   - carril_onehot: lane index -> one-hot per-lane vector
// -----------------------------------------------------------------------------
package acceso_pkg;

    localparam int CLAVE_W    = 16;
    localparam int N_CARRILES = 2;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        VALIDANDO = 2'd1,
        ABIERTA   = 2'd2,
        RECHAZO   = 2'd3
    } estado_t;

    function automatic logic [N_CARRILES-1:0] carril_onehot(input logic carril);
        logic [N_CARRILES-1:0] v;
        v         = '0;
        v[carril] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/contador_ocupacion.sv
// -----------------------------------------------------------------------------
// contador_ocupacion
// Saturating vehicle occupancy counter.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   inc_i          : one vehicle entered (ignored when already full)
//   dec_i          : one vehicle left (ignored when already empty)
//   cuenta_o       : current occupancy
//   lleno_o        : occupancy equals CAPACIDAD
// Simultaneous inc and dec cancel out.
// -----------------------------------------------------------------------------
module contador_ocupacion #(
    parameter int CAPACIDAD = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cuenta_o,
    output logic             lleno_o
);

    logic [CNT_W-1:0] cuenta_q;
    logic [CNT_W-1:0] cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (inc_i && !dec_i && (cuenta_q < CNT_W'(CAPACIDAD))) begin
            cuenta_d = cuenta_q + 1'b1;
        end else if (dec_i && !inc_i && (cuenta_q != '0)) begin
            cuenta_d = cuenta_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta_o = cuenta_q;
    assign lleno_o  = (cuenta_q == CNT_W'(CAPACIDAD));

endmodule

// File: rtl/arbitro_carriles.sv
// -----------------------------------------------------------------------------
// arbitro_carriles
// Two-lane parking entry arbiter sharing a single PIN validator.
// Ports:
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   sensor_llegada_vehiculo  : per-lane vehicle waiting at gate (level)
//   sensor_ingreso_vehiculo  : per-lane vehicle passed gate (pulse)
//   sensor_salida_vehiculo   : vehicle left the lot (pulse)
//   clave_carril0/1          : PIN keyed in at lane 0 / lane 1
//   validar_ack, validar_ok  : validator result strobe and verdict
//   validar_req              : request to validator (held while validating)
//   clave_validar            : latched PIN of the lane being validated
//   senal_compuerta          : per-lane gate open
//   senal_rechazo            : per-lane one-cycle reject pulse
//   senal_lleno              : lot full
//   ocupacion                : current vehicle count
// Every output is decoded from registered state only.
// -----------------------------------------------------------------------------
module arbitro_carriles
    import acceso_pkg::*;
#(
    parameter int CAPACIDAD      = 8,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            sensor_llegada_vehiculo,
    input  logic [1:0]            sensor_ingreso_vehiculo,
    input  logic                  sensor_salida_vehiculo,
    input  logic [CLAVE_W-1:0]    clave_carril0,
    input  logic [CLAVE_W-1:0]    clave_carril1,
    input  logic                  validar_ack,
    input  logic                  validar_ok,
    output logic                  validar_req,
    output logic [CLAVE_W-1:0]    clave_validar,
    output logic [1:0]            senal_compuerta,
    output logic [1:0]            senal_rechazo,
    output logic                  senal_lleno,
    output logic [CNT_W-1:0]      ocupacion
);

    localparam int TMO_W = (TIMEOUT_CICLOS < 2) ? 1 : $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [TMO_W-1:0] TMO_ULTIMO = TMO_W'(TIMEOUT_CICLOS - 1);

    estado_t              estado_q, estado_d;
    logic                 carril_q, carril_d;
    logic                 ptr_q, ptr_d;
    logic [1:0]           bloqueo_q, bloqueo_d;
    logic [1:0]           llegada_q;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [CLAVE_W-1:0]   clave_q, clave_d;

    logic                 inc_ocup;
    logic                 lleno;
    logic [1:0]           elegible;
    logic                 sel;

    // Arrival sensors are registered first so the grant decision never sees
    // a raw input; this places validar_req one edge after llegada is sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            llegada_q <= '0;
        end else begin
            llegada_q <= sensor_llegada_vehiculo;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= REPOSO;
            carril_q  <= 1'b0;
            ptr_q     <= 1'b0;
            bloqueo_q <= '0;
            tmo_q     <= '0;
            clave_q   <= '0;
        end else begin
            estado_q  <= estado_d;
            carril_q  <= carril_d;
            ptr_q     <= ptr_d;
            bloqueo_q <= bloqueo_d;
            tmo_q     <= tmo_d;
            clave_q   <= clave_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        carril_d  = carril_q;
        ptr_d     = ptr_q;
        clave_d   = clave_q;
        tmo_d     = '0;
        inc_ocup  = 1'b0;
        // A lane's block is lifted as soon as its vehicle is gone.
        bloqueo_d = bloqueo_q & llegada_q;
        elegible  = llegada_q & ~bloqueo_q & {2{~lleno}};
        sel       = (elegible == 2'b11) ? ptr_q : elegible[1];

        case (estado_q)
            REPOSO: begin
                if (elegible != 2'b00) begin
                    carril_d = sel;
                    clave_d  = sel ? clave_carril1 : clave_carril0;
                    estado_d = VALIDANDO;
                end
            end
            VALIDANDO: begin
                if (validar_ack) begin
                    estado_d = validar_ok ? ABIERTA : RECHAZO;
                end else if (tmo_q == TMO_ULTIMO) begin
                    estado_d = RECHAZO;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ABIERTA: begin
                // Passage takes priority over the vehicle backing away.
                if (sensor_ingreso_vehiculo[carril_q]) begin
                    inc_ocup = 1'b1;
                    estado_d = REPOSO;
                    ptr_d    = ~carril_q;
                end else if (!llegada_q[carril_q]) begin
                    estado_d = REPOSO;
                    ptr_d    = ~carril_q;
                end
            end
            RECHAZO: begin
                bloqueo_d[carril_q] = 1'b1;
                estado_d            = REPOSO;
                ptr_d               = ~carril_q;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    contador_ocupacion #(
        .CAPACIDAD (CAPACIDAD),
        .CNT_W     (CNT_W)
    ) u_contador (
        .clock    (clock),
        .reset    (reset),
        .inc_i    (inc_ocup),
        .dec_i    (sensor_salida_vehiculo),
        .cuenta_o (ocupacion),
        .lleno_o  (lleno)
    );

    assign validar_req     = (estado_q == VALIDANDO);
    assign clave_validar   = (estado_q == VALIDANDO) ? clave_q : '0;
    assign senal_compuerta = (estado_q == ABIERTA) ? carril_onehot(carril_q) : 2'b00;
    assign senal_rechazo   = (estado_q == RECHAZO) ? carril_onehot(carril_q) : 2'b00;
    assign senal_lleno     = lleno;

endmodule

// File: tb/tb_arbitro_carriles.sv
// -----------------------------------------------------------------------------
// tb_arbitro_carriles
// Directed bench for arbitro_carriles with default parameters
// (CAPACIDAD=8, CNT_W=4, TIMEOUT_CICLOS=16).
// -----------------------------------------------------------------------------
module tb_arbitro_carriles;

    logic        clock;
    logic        reset;
    logic [1:0]  sensor_llegada_vehiculo;
    logic [1:0]  sensor_ingreso_vehiculo;
    logic        sensor_salida_vehiculo;
    logic [15:0] clave_carril0;
    logic [15:0] clave_carril1;
    logic        validar_ack;
    logic        validar_ok;
    logic        validar_req;
    logic [15:0] clave_validar;
    logic [1:0]  senal_compuerta;
    logic [1:0]  senal_rechazo;
    logic        senal_lleno;
    logic [3:0]  ocupacion;

    int checks = 0;
    int errors = 0;

    arbitro_carriles dut (
        .clock                   (clock),
        .reset                   (reset),
        .sensor_llegada_vehiculo (sensor_llegada_vehiculo),
        .sensor_ingreso_vehiculo (sensor_ingreso_vehiculo),
        .sensor_salida_vehiculo  (sensor_salida_vehiculo),
        .clave_carril0           (clave_carril0),
        .clave_carril1           (clave_carril1),
        .validar_ack             (validar_ack),
        .validar_ok              (validar_ok),
        .validar_req             (validar_req),
        .clave_validar           (clave_validar),
        .senal_compuerta         (senal_compuerta),
        .senal_rechazo           (senal_rechazo),
        .senal_lleno             (senal_lleno),
        .ocupacion               (ocupacion)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full accepted passage on lane 0; optionally a departure on the same
    // edge as the entry.
    task automatic paso_completo0(input logic salida_a_la_vez);
        sensor_llegada_vehiculo = 2'b01;
        tick();
        tick();
        validar_ack = 1'b1;
        validar_ok  = 1'b1;
        tick();
        validar_ack = 1'b0;
        validar_ok  = 1'b0;
        sensor_ingreso_vehiculo = 2'b01;
        sensor_salida_vehiculo  = salida_a_la_vez;
        sensor_llegada_vehiculo = 2'b00;
        tick();
        sensor_ingreso_vehiculo = 2'b00;
        sensor_salida_vehiculo  = 1'b0;
        tick();
    endtask

    initial begin
        reset                   = 1'b1;
        sensor_llegada_vehiculo = 2'b00;
        sensor_ingreso_vehiculo = 2'b00;
        sensor_salida_vehiculo  = 1'b0;
        clave_carril0           = 16'h0000;
        clave_carril1           = 16'h0000;
        validar_ack             = 1'b0;
        validar_ok              = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_req",   validar_req,     1'b0);
        chk("rst_clave", clave_validar,   16'h0000);
        chk("rst_comp",  senal_compuerta, 2'b00);
        chk("rst_rech",  senal_rechazo,   2'b00);
        chk("rst_lleno", senal_lleno,     1'b0);
        chk("rst_ocup",  ocupacion,       4'd0);
        reset = 1'b0;
        tick();

        // Lane 0 accepted after 3 cycles of waiting
        sensor_llegada_vehiculo = 2'b01;
        clave_carril0           = 16'h1234;
        tick();
        chk("t1_req_n",   validar_req,   1'b0);
        tick();
        chk("t1_req_n1",  validar_req,   1'b1);
        chk("t1_clave",   clave_validar, 16'h1234);
        tick();
        tick();
        chk("t1_req_hold", validar_req,  1'b1);
        validar_ack = 1'b1;
        validar_ok  = 1'b1;
        tick();
        validar_ack = 1'b0;
        validar_ok  = 1'b0;
        chk("t1_comp",    senal_compuerta, 2'b01);
        chk("t1_req_off", validar_req,     1'b0);
        chk("t1_ocup0",   ocupacion,       4'd0);
        sensor_ingreso_vehiculo = 2'b01;
        tick();
        sensor_ingreso_vehiculo = 2'b00;
        sensor_llegada_vehiculo = 2'b00;
        chk("t1_ocup1",   ocupacion,       4'd1);
        chk("t1_comp_c",  senal_compuerta, 2'b00);
        tick();
        tick();

        // Both lanes arrive together after reset: lane 0 then lane 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t2_ocup_rst", ocupacion, 4'd0);
        sensor_llegada_vehiculo = 2'b11;
        clave_carril0           = 16'hAAAA;
        clave_carril1           = 16'hBBBB;
        tick();
        tick();
        chk("t2_clave0", clave_validar, 16'hAAAA);
        validar_ack = 1'b1;
        validar_ok  = 1'b1;
        tick();
        validar_ack = 1'b0;
        validar_ok  = 1'b0;
        chk("t2_comp0", senal_compuerta, 2'b01);
        sensor_ingreso_vehiculo = 2'b01;
        tick();
        sensor_ingreso_vehiculo = 2'b00;
        tick();
        chk("t2_clave1", clave_validar, 16'hBBBB);
        validar_ack = 1'b1;
        validar_ok  = 1'b1;
        tick();
        validar_ack = 1'b0;
        validar_ok  = 1'b0;
        chk("t2_comp1", senal_compuerta, 2'b10);
        sensor_ingreso_vehiculo = 2'b10;
        sensor_llegada_vehiculo = 2'b00;
        tick();
        sensor_ingreso_vehiculo = 2'b00;
        chk("t2_ocup2", ocupacion, 4'd2);
        tick();
        chk("t2_idle_req", validar_req, 1'b0);

        // Ingreso outside ABIERTA and ack outside VALIDANDO are ignored
        sensor_ingreso_vehiculo = 2'b01;
        validar_ack             = 1'b1;
        validar_ok              = 1'b1;
        tick();
        sensor_ingreso_vehiculo = 2'b00;
        validar_ack             = 1'b0;
        validar_ok              = 1'b0;
        chk("ign_ocup", ocupacion,       4'd2);
        chk("ign_comp", senal_compuerta, 2'b00);

        // Lane 1 rejected, then blocked until llegada drops and rises
        sensor_llegada_vehiculo = 2'b10;
        clave_carril1           = 16'h5555;
        tick();
        tick();
        chk("t3_req",   validar_req,   1'b1);
        chk("t3_clave", clave_validar, 16'h5555);
        validar_ack = 1'b1;
        validar_ok  = 1'b0;
        tick();
        validar_ack = 1'b0;
        chk("t3_rech",     senal_rechazo,   2'b10);
        chk("t3_comp",     senal_compuerta, 2'b00);
        tick();
        chk("t3_rech_end", senal_rechazo,   2'b00);
        tick();
        tick();
        chk("t3_blocked",  validar_req,     1'b0);
        sensor_llegada_vehiculo = 2'b00;
        tick();
        tick();
        sensor_llegada_vehiculo = 2'b10;
        tick();
        tick();
        chk("t3_regrant",  validar_req,     1'b1);

        // No ack: timeout after 16 cycles of request
        for (int i = 0; i < 15; i++) tick();
        chk("t4_req_last", validar_req,   1'b1);
        tick();
        chk("t4_req_drop", validar_req,   1'b0);
        chk("t4_rech",     senal_rechazo, 2'b10);
        sensor_llegada_vehiculo = 2'b00;
        tick();
        chk("t4_rech_end", senal_rechazo, 2'b00);
        tick();

        // Fill the lot to capacity
        for (int i = 0; i < 6; i++) paso_completo0(1'b0);
        chk("t5_ocup8",  ocupacion,   4'd8);
        chk("t5_lleno",  senal_lleno, 1'b1);
        sensor_llegada_vehiculo = 2'b01;
        tick();
        tick();
        tick();
        chk("t5_noreq",  validar_req, 1'b0);
        sensor_llegada_vehiculo = 2'b00;
        tick();
        sensor_salida_vehiculo = 1'b1;
        tick();
        sensor_salida_vehiculo = 1'b0;
        chk("t5_ocup7",  ocupacion,   4'd7);
        chk("t5_nolleno", senal_lleno, 1'b0);
        paso_completo0(1'b1);
        chk("t5_incdec", ocupacion,   4'd7);
        sensor_salida_vehiculo = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("t5_vacio",  ocupacion,   4'd0);
        tick();
        sensor_salida_vehiculo = 1'b0;
        chk("t5_sat0",   ocupacion,   4'd0);

        // Reset while the gate is open
        paso_completo0(1'b0);
        chk("t6_ocup1", ocupacion, 4'd1);
        sensor_llegada_vehiculo = 2'b01;
        tick();
        tick();
        validar_ack = 1'b1;
        validar_ok  = 1'b1;
        tick();
        validar_ack = 1'b0;
        validar_ok  = 1'b0;
        chk("t6_comp_open", senal_compuerta, 2'b01);
        reset = 1'b1;
        tick();
        chk("t6_comp_rst", senal_compuerta, 2'b00);
        chk("t6_ocup_rst", ocupacion,       4'd0);
        chk("t6_req_rst",  validar_req,     1'b0);
        reset = 1'b0;
        sensor_llegada_vehiculo = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_carriles.md
ARBITRO_CARRILES -- requirements
Module: arbitro_carriles

Interface
REQ-001 Parameter CAPACIDAD, default 8, lot capacity in vehicles.
REQ-002 Parameter CNT_W, default 4, width of occupancy count; SHALL satisfy 2**CNT_W > CAPACIDAD.
REQ-003 Parameter TIMEOUT_CICLOS, default 16, max cycles waiting for validator acknowledge.
REQ-004 clock  in  1  single clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sensor_llegada_vehiculo  in  2  per-lane vehicle present at gate (level), bit 0 = lane 0.
REQ-007 sensor_ingreso_vehiculo  in  2  per-lane vehicle passed gate (1-cycle pulse).
REQ-008 sensor_salida_vehiculo  in  1  vehicle left lot (1-cycle pulse).
REQ-009 clave_carril0 / clave_carril1  in  16 each  PIN entered at lane 0 / lane 1.
REQ-010 validar_ack  in  1  shared PIN validator result valid.
REQ-011 validar_ok  in  1  PIN correct; meaningful only with validar_ack.
REQ-012 validar_req  out  1  request to validator, held until ack or timeout.
REQ-013 clave_validar  out  16  PIN presented to validator.
REQ-014 senal_compuerta  out  2  per-lane gate open.
REQ-015 senal_rechazo  out  2  per-lane reject pulse.
REQ-016 senal_lleno  out  1  lot full.
REQ-017 ocupacion  out  CNT_W  current vehicle count.

Function
REQ-018 FSM states SHALL be REPOSO, VALIDANDO, ABIERTA, RECHAZO; one lane served at a time.
REQ-019 In REPOSO a lane SHALL be eligible when its llegada=1, its bloqueo flag=0 and ocupacion<CAPACIDAD.
REQ-020 Both eligible -> grant lane given by round-robin pointer; one eligible -> grant it; grant latches lane index and its clave, state -> VALIDANDO.
REQ-021 Latency: llegada sampled high at edge N SHALL give validar_req=1 and clave_validar=latched clave after edge N+1.
REQ-022 In VALIDANDO, ack with ok=1 -> ABIERTA; ack with ok=0 -> RECHAZO; TIMEOUT_CICLOS cycles without ack -> RECHAZO; validar_req deasserts on leaving VALIDANDO.
REQ-023 In ABIERTA, senal_compuerta[lane]=1 until ingreso[lane]=1 (ocupacion+1, -> REPOSO) or llegada[lane]=0 (no increment, -> REPOSO).
REQ-024 RECHAZO SHALL last exactly one cycle with senal_rechazo[lane]=1, set bloqueo[lane], -> REPOSO.
REQ-025 bloqueo[i] SHALL clear when llegada[i]=0.
REQ-026 Pointer SHALL flip to the other lane whenever ABIERTA or RECHAZO is exited.
REQ-027 ingreso on a non-granted lane or outside ABIERTA SHALL be ignored; ack outside VALIDANDO ignored.
REQ-028 salida SHALL decrement ocupacion when >0, ignored at 0; simultaneous increment and decrement leaves ocupacion unchanged; count never exceeds CAPACIDAD.
REQ-029 senal_lleno SHALL equal (ocupacion == CAPACIDAD); lot full mid-transaction does not abort the current lane.
REQ-030 All outputs SHALL be decoded from registers only; no input-to-output combinational path.

Reset
REQ-031 reset SHALL force state REPOSO, ocupacion 0, pointer lane 0, bloqueo 00, timeout counter 0, latched clave 0.
REQ-032 During and after reset all outputs SHALL be 0 (senal_lleno 0 unless CAPACIDAD=0, which is illegal).
REQ-033 reset mid-transaction SHALL close the gate and drop validar_req on the next edge; pending ack ignored.

Structure
REQ-034 Package acceso_pkg SHALL hold the FSM state type, CLAVE_W=16 and N_CARRILES=2.
REQ-035 Occupancy counter SHALL be a sub-module contador_ocupacion (inc, dec, saturation, lleno).

Verification
REQ-036 Lane 0 llegada, clave 16'h1234, ack ok=1 after 3 cycles, ingreso[0] -> req 1 cycle after llegada, compuerta=01, ocupacion 0->1.
REQ-037 Both lanes arrive same cycle after reset -> lane 0 served first, then lane 1; pointer alternates.
REQ-038 Lane 1 ack ok=0 -> rechazo=10 for 1 cycle; lane 1 not re-granted until llegada[1] drops and rises.
REQ-039 No ack for 16 cycles -> RECHAZO, validar_req drops, rechazo pulse on granted lane.
REQ-040 Fill to 8, arrival -> no req, lleno=1; ingreso and salida same cycle at 7 -> stays 7; salida at 0 -> stays 0.
REQ-041 reset asserted while ABIERTA -> compuerta=00, ocupacion=0 next edge.
